// File: rtl/vga_timing_pkg.sv
// Shared state type, timing presets and helpers for the VGA raster timing controller.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vga_state_e;

    localparam int VGA_CNT_W = 12;
    localparam int VGA_CNT_MAX = (1 << VGA_CNT_W) - 1;

    // 640x480 @ 60 Hz
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 1280x720 @ 60 Hz
    localparam int VGA720_H_ACTIVE = 1280;
    localparam int VGA720_H_FP     = 110;
    localparam int VGA720_H_SYNC   = 40;
    localparam int VGA720_H_BP     = 220;
    localparam int VGA720_V_ACTIVE = 720;
    localparam int VGA720_V_FP     = 5;
    localparam int VGA720_V_SYNC   = 5;
    localparam int VGA720_V_BP     = 20;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Half-open window test [lo, hi) on a raster counter.
    function automatic logic vga_in_window(input logic [VGA_CNT_W-1:0] cnt,
                                           input logic [VGA_CNT_W-1:0] lo,
                                           input logic [VGA_CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Free-running clock divider; pix_tick_o is a registered one-clk pulse every CLK_DIV clocks.
module vga_pix_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic pix_tick_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             pix_tick_q;
    logic             pix_tick_d;

    always_comb begin
        div_cnt_d  = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        // Registered so the pulse lines up with the value div_cnt_q takes next.
        pix_tick_d = (div_cnt_d == DIV_LAST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q  <= '0;
            pix_tick_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            pix_tick_q <= pix_tick_d;
        end
    end

    assign pix_tick_o = pix_tick_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster timing controller: pixel tick, h/v counters, sync and video-enable generation
// with start/stop only at frame boundaries.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int CLK_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    output logic                 busy,
    output logic                 pix_tick,
    output logic [VGA_CNT_W-1:0] pixel_x,
    output logic [VGA_CNT_W-1:0] pixel_y,
    output logic                 video_on,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [15:0]          frame_count,
    output logic [VGA_CNT_W-1:0] hres,
    output logic [VGA_CNT_W-1:0] vres,
    output vga_state_e           dbg_state
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [VGA_CNT_W-1:0] H_LAST = VGA_CNT_W'(H_TOTAL - 1);
    localparam logic [VGA_CNT_W-1:0] V_LAST = VGA_CNT_W'(V_TOTAL - 1);
    localparam logic [VGA_CNT_W-1:0] H_ACT  = VGA_CNT_W'(H_ACTIVE);
    localparam logic [VGA_CNT_W-1:0] V_ACT  = VGA_CNT_W'(V_ACTIVE);
    localparam logic [VGA_CNT_W-1:0] HS_BEG = VGA_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [VGA_CNT_W-1:0] HS_END = VGA_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VGA_CNT_W-1:0] VS_BEG = VGA_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [VGA_CNT_W-1:0] VS_END = VGA_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > VGA_CNT_MAX || V_TOTAL > VGA_CNT_MAX) begin : g_bad_total
        $error("vga_timing_ctrl: H_TOTAL/V_TOTAL exceed the 12-bit raster counters");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_ctrl: CLK_DIV must be at least 1");
    end

    vga_state_e           state_q, state_d;
    logic [VGA_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [VGA_CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [15:0]          frame_count_q, frame_count_d;
    logic                 busy_q, busy_d;
    logic                 video_on_q, video_on_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 line_start_q, line_start_d;
    logic                 frame_start_q, frame_start_d;
    logic                 tick;
    logic                 h_last;
    logic                 v_last;
    logic                 frame_last;

    vga_pix_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick (
        .clk_i      (clk),
        .rst_i      (reset),
        .pix_tick_o (tick)
    );

    assign h_last     = (h_cnt_q == H_LAST);
    assign v_last     = (v_cnt_q == V_LAST);
    assign frame_last = h_last && v_last;

    // Next state, counters and pulses; nothing moves except on a pixel tick.
    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_count_d = frame_count_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d       = RUN;
                        frame_start_d = 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    if (h_last) begin
                        h_cnt_d      = '0;
                        line_start_d = 1'b1;
                        v_cnt_d      = v_last ? '0 : v_cnt_q + VGA_CNT_W'(1);
                    end else begin
                        h_cnt_d = h_cnt_q + VGA_CNT_W'(1);
                    end
                    if (frame_last) begin
                        frame_count_d = frame_count_q + 16'd1;
                    end

                    if (state_q == RUN) begin
                        frame_start_d = frame_last;
                        if (!run) begin
                            state_d = DRAIN;
                        end
                    end else if (run) begin
                        // Re-armed while draining: keep scanning without a gap.
                        state_d       = RUN;
                        frame_start_d = frame_last;
                    end else if (frame_last) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                end
            endcase
        end
    end

    // Raster-derived outputs are computed from the next counters so they land together.
    always_comb begin
        busy_d     = (state_d != IDLE);
        video_on_d = 1'b0;
        hsync_d    = ~SYNC_POL;
        vsync_d    = ~SYNC_POL;
        if (state_d != IDLE) begin
            video_on_d = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
            if (vga_in_window(h_cnt_d, HS_BEG, HS_END)) begin
                hsync_d = SYNC_POL;
            end
            if (vga_in_window(v_cnt_d, VS_BEG, VS_END)) begin
                vsync_d = SYNC_POL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_count_q <= '0;
            busy_q        <= 1'b0;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_count_q <= frame_count_d;
            busy_q        <= busy_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign busy        = busy_q;
    assign pix_tick    = tick;
    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign hres        = H_ACT;
    assign vres        = V_ACT;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl on a tiny 14x7 raster with a 2-clock pixel.
module tb_vga_timing_ctrl;
  import vga_timing_pkg::*;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int H_TOT = HA + HF + HS + HB;
  localparam int V_TOT = VA + VF + VS + VB;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int DIV = 2;
  localparam bit SP = 1'b0;

  logic clk, reset, run;
  logic busy, pix_tick, video_on, hsync, vsync, line_start, frame_start;
  logic [11:0] pixel_x, pixel_y, hres, vres;
  logic [15:0] frame_count;
  vga_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  // model: linear raster position plus scan mode (0 idle, 1 run, 2 drain)
  int m_mode, m_pos, m_fc, m_edges;
  int m_ls, m_fs;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(SP), .CLK_DIV(DIV)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .busy(busy), .pix_tick(pix_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count),
    .hres(hres), .vres(vres), .dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_fc = 0; m_edges = 0; m_ls = 0; m_fs = 0;
  endtask

  function automatic int exp_pix();
    return (m_edges > 0 && (m_edges % DIV) == DIV - 1) ? 1 : 0;
  endfunction

  // Advance the model across the coming clock edge, using the run level it will sample.
  task automatic model_step();
    int tick_now;
    int last;
    tick_now = exp_pix();
    m_edges++;
    m_ls = 0;
    m_fs = 0;
    if (tick_now == 1) begin
      if (m_mode == 0) begin
        if (run) begin
          m_mode = 1;
          m_fs = 1;
        end
      end else begin
        last = (m_pos == FRAME - 1) ? 1 : 0;
        if (m_pos % H_TOT == H_TOT - 1) m_ls = 1;
        m_pos = (m_pos + 1) % FRAME;
        if (last == 1) m_fc = (m_fc + 1) % 65536;
        if (m_mode == 1) begin
          if (last == 1) m_fs = 1;
          if (!run) m_mode = 2;
        end else if (run) begin
          m_mode = 1;
          if (last == 1) m_fs = 1;
        end else if (last == 1) begin
          m_mode = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    int x, y, on, hs_in, vs_in;
    x = m_pos % H_TOT;
    y = m_pos / H_TOT;
    on = (m_mode != 0) ? 1 : 0;
    hs_in = (on == 1 && x >= HA + HF && x < HA + HF + HS) ? 1 : 0;
    vs_in = (on == 1 && y >= VA + VF && y < VA + VF + VS) ? 1 : 0;
    check("pixel_x", pixel_x, x);
    check("pixel_y", pixel_y, y);
    check("video_on", video_on, (on == 1 && x < HA && y < VA) ? 1 : 0);
    check("hsync", hsync, (hs_in == 1) ? int'(SP) : int'(!SP));
    check("vsync", vsync, (vs_in == 1) ? int'(SP) : int'(!SP));
    check("busy", busy, on);
    check("pix_tick", pix_tick, exp_pix());
    check("line_start", line_start, m_ls);
    check("frame_start", frame_start, m_fs);
    check("frame_count", frame_count, m_fc);
    check("hres", hres, HA);
    check("vres", vres, VA);
    check("state_drain", (dbg_state == DRAIN) ? 1 : 0, (m_mode == 2) ? 1 : 0);
  endtask

  // scoreboard: compare on the falling edge, then step the model for the next rising edge
  always @(negedge clk) begin
    if (reset) model_reset();
    compare_all();
    if (!reset) model_step();
  end

  // driver tasks: inputs change just after a rising edge
  task automatic wait_tick_at(input int h, input int v, input int budget, input string name);
    int found = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      @(posedge clk); #1;
      if (pix_tick && pixel_x == 12'(h) && pixel_y == 12'(v)) found = 1;
    end
    check(name, found, 1);
  endtask

  task automatic start_run();
    int found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      @(posedge clk); #1;
      if (pix_tick) found = 1;
    end
    check("start_tick", found, 1);
    run = 1'b1;
  endtask

  initial begin
    int n, fs_cnt, ls_cnt, max_x, vid_cnt, hlow_cnt, vlow_cnt, tick_cnt, drops, found;

    reset = 1'b1;
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: idle after reset
    repeat (100) @(posedge clk);
    #1;
    check("t1_x", pixel_x, 0);
    check("t1_y", pixel_y, 0);
    check("t1_hsync", hsync, 1);
    check("t1_vsync", vsync, 1);
    check("t1_video", video_on, 0);
    check("t1_busy", busy, 0);

    // 2 + 3: start and free-run three frames
    start_run();
    n = 0; fs_cnt = 0; ls_cnt = 0; max_x = 0;
    vid_cnt = 0; hlow_cnt = 0; vlow_cnt = 0; tick_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      n++;
      if (n <= 2 * FRAME) begin
        vid_cnt += int'(video_on);
        hlow_cnt += int'(!hsync);
        vlow_cnt += int'(!vsync);
        tick_cnt += int'(pix_tick);
        if (n == 1) check("t2_fs_first", frame_start, 1);
      end
      fs_cnt += int'(frame_start);
      ls_cnt += int'(line_start);
      if (int'(pixel_x) > max_x) max_x = int'(pixel_x);
      if (frame_count == 16'd3) break;
    end
    check("t2_video_cycles", vid_cnt, 64);
    check("t2_hsync_low", hlow_cnt, 28);
    check("t2_vsync_low", vlow_cnt, 28);
    check("t2_ticks", tick_cnt, 98);
    check("t3_cycles_to_fc3", n, 589);
    check("t3_frame_starts", fs_cnt, 4);
    check("t3_line_starts", ls_cnt, 21);
    check("t3_max_x", max_x, 13);

    // 4: stop mid-frame, drain to the frame end
    wait_tick_at(3, 2, 400, "t4_find_3_2");
    run = 1'b0;
    n = 0; found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(posedge clk); #1;
      n++;
      if (!busy) found = 1;
    end
    check("t4_idle_reached", found, 1);
    check("t4_cycles", n, 133);
    check("t4_fc", frame_count, 4);
    check("t4_x", pixel_x, 0);
    check("t4_y", pixel_y, 0);

    // 5: re-arm while draining
    repeat (5) @(posedge clk);
    start_run();
    @(posedge clk); #1;
    check("t5_fs_start", frame_start, 1);
    wait_tick_at(0, 1, 100, "t5_find_0_1");
    run = 1'b0;
    wait_tick_at(0, 4, 200, "t5_find_0_4");
    check("t5_in_drain", (dbg_state == DRAIN) ? 1 : 0, 1);
    run = 1'b1;
    drops = 0; found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(posedge clk); #1;
      if (!busy) drops++;
      if (frame_start) found = 1;
    end
    check("t5_fs_seen", found, 1);
    check("t5_no_gap", drops, 0);
    check("t5_x", pixel_x, 0);
    check("t5_y", pixel_y, 0);
    check("t5_fc", frame_count, 5);

    // 6: asynchronous reset mid-frame, then restart
    wait_tick_at(5, 1, 100, "t6_find_5_1");
    reset = 1'b1;
    run = 1'b0;
    #1;
    check("t6_x", pixel_x, 0);
    check("t6_y", pixel_y, 0);
    check("t6_video", video_on, 0);
    check("t6_hsync", hsync, 1);
    check("t6_vsync", vsync, 1);
    check("t6_busy", busy, 0);
    check("t6_fc", frame_count, 0);
    check("t6_pix", pix_tick, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t6_still_idle", busy, 0);
    start_run();
    @(posedge clk); #1;
    check("t6_fs_restart", frame_start, 1);
    check("t6_busy_restart", busy, 1);
    check("t6_video_restart", video_on, 1);
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Raster timing controller that sequences the per-pixel image generators of the VGA simulation. It produces the pixel-enable tick, horizontal and vertical counters, the pixel_x/pixel_y/video_on interface consumed by image modules, and hsync/vsync.
- Supports start/stop at frame boundaries, so the C-side monitor model never sees a truncated frame.
- Sits between the top-level clock/reset and every image-generating module.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
- CLK_DIV, 1, clk cycles per pixel (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  request to scan frames
- busy  out  1  high while state is RUN or DRAIN
- pix_tick  out  1  one-clk pulse marking a pixel step
- pixel_x  out  12  horizontal counter h_cnt
- pixel_y  out  12  vertical counter v_cnt
- video_on  out  1  inside the active area
- hsync  out  1  horizontal sync at SYNC_POL level
- vsync  out  1  vertical sync at SYNC_POL level
- line_start  out  1  one-clk pulse when h_cnt wraps to 0 while RUN/DRAIN
- frame_start  out  1  one-clk pulse when (h_cnt, v_cnt) becomes (0,0) while RUN
- frame_count  out  16  completed-frame counter, wraps
- hres  out  12  constant H_ACTIVE
- vres  out  12  constant V_ACTIVE

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be ≤ 4095 (static assertion).
- Divider:
  - div_cnt runs 0..CLK_DIV-1 continuously, including in IDLE.
  - pix_tick = (div_cnt == CLK_DIV-1); CLK_DIV = 1 gives pix_tick every cycle.
- FSM IDLE/RUN/DRAIN, all transitions on pix_tick only:
  - IDLE & run → RUN. Counters are already (0,0); frame_start pulses together with that tick's output update.
  - RUN & !run → DRAIN.
  - DRAIN & run → RUN, with no gap in scanning.
  - DRAIN at the last pixel (H_TOTAL-1, V_TOTAL-1) with !run → IDLE, counters go to (0,0).
  - RUN at the last pixel: counters wrap to (0,0), frame_count increments, frame_start pulses.
  - DRAIN → IDLE also increments frame_count.
- Counters (RUN/DRAIN, on pix_tick):
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt at V_TOTAL-1 wraps to 0.
  - No wrap glitch: h_cnt never equals H_TOTAL.
- Outputs:
  - All registered.
  - pixel_x, pixel_y, video_on, hsync and vsync always describe the same (h_cnt, v_cnt) in the same cycle, so there is zero skew between them.
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE) && state != IDLE.
  - hsync asserted when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted on the same rule using the v parameters, applied to v_cnt.
  - In IDLE, both syncs are at the inactive level.
  - Pulses (pix_tick, line_start, frame_start) last exactly one clk.
- Reset values (asynchronous, immediate): state IDLE, div_cnt 0, counters 0, video_on 0, hsync/vsync = !SYNC_POL, all pulses 0, frame_count 0, busy 0.
- Reset mid-frame: outputs go to reset values immediately. After reset deasserts, scanning resumes only from IDLE via run.
- run toggled between ticks: sampled only on pix_tick; glitches between ticks are ignored.

Decomposition:
- Shared package vga_timing_pkg:
  - state enum vga_state_e {IDLE, RUN, DRAIN}
  - default 640x480 timing localparams plus a 1280x720 set
  - function to compute the total from the four segments
- One sub-module: vga_pix_tick (divider, parameter CLK_DIV, outputs pix_tick).

Test Plan:
All tests use H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), CLK_DIV = 2, SYNC_POL = 0.
1. Reset then idle, run = 0 → pixel_x = pixel_y = 0, hsync = vsync = 1, video_on = 0, busy = 0 for 100 cycles.
2. run = 1 → frame_start pulses once; pix_tick every 2nd clk. video_on is high for h 0..7 and v 0..3. hsync is low for h 10..11 on every line; vsync is low for v 5 only.
3. Free-run 3 frames → frame_count = 3 after 3×98 ticks. line_start pulses every 14 ticks; pixel_x never exceeds 13.
4. run = 0 at (h 3, v 2) → DRAIN; scanning continues to (13, 6), then IDLE, busy = 0, frame_count +1.
5. In DRAIN, set run = 1 at v 4 → no interruption; the next frame starts at (0,0) with a frame_start pulse.
6. Assert reset at (h 5, v 1) for 1 cycle → all outputs at reset values in the same cycle; restart yields frame_start at the first tick after run = 1.
